alu181_seq: RTL and testbench

- Parametrised, slice-serial successor to the dual-74181 datapath.
- Holds operands up to WIDTH bits and runs them through one 4-bit 74181-equivalent slice per clock, least-significant slice first.
- Carry passes between slices through a register.
- A start/busy/done handshake replaces the fixed 8-bit combinational chain; it sits behind the SPI config/status registers, driven by a config-register start bit.

---
 rtl/alu181_pkg.sv | 18 +
 rtl/alu181_slice.sv | 31 +++
 rtl/alu181_seq.sv | 152 +++++++++++++++
 tb/tb_alu181_seq.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/alu181_pkg.sv
// Shared types and constants for the slice-serial 74181 datapath.
package alu181_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Common function selects; S_XOR is only XOR when m=1.
  localparam logic [3:0] S_ADD    = 4'b1001;
  localparam logic [3:0] S_SUB    = 4'b0110;
  localparam logic [3:0] S_XOR    = 4'b0110;
  localparam logic [3:0] S_PASS_A = 4'b0000;

endpackage

// File: rtl/alu181_slice.sv
// One 4-bit 74181-equivalent slice, active-high data, active-low carry pins.
module alu181_slice
  import alu181_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cn,
  input  logic [3:0]         s,
  input  logic               m,
  output logic [SLICE_W-1:0] f,
  output logic               cn4
);

  // Arithmetic is or_term + and_term + carry; and_term is always a subset of or_term.
  logic [SLICE_W-1:0] or_term;
  logic [SLICE_W-1:0] and_term;
  logic [SLICE_W:0]   c;

  assign or_term  = a | (b & {SLICE_W{s[0]}}) | (~b & {SLICE_W{s[1]}});
  assign and_term = (a & b & {SLICE_W{s[3]}}) | (a & ~b & {SLICE_W{s[2]}});
  assign c[0]     = ~cn;

  for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_carry
    assign c[gi+1] = and_term[gi] | (or_term[gi] & c[gi]);
  end

  // In logic mode the carry is not consumed, so the incoming carry is passed through unchanged.
  assign f   = m ? ~(or_term ^ and_term) : (or_term ^ and_term ^ c[SLICE_W-1:0]);
  assign cn4 = m ? cn : ~c[SLICE_W];

endmodule

// File: rtl/alu181_seq.sv
// Slice-serial 74181 ALU: one 4-bit slice per clock, LSB slice first, registered carry.
module alu181_seq
  import alu181_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cn,
  input  logic             chain,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cn_out,
  output logic             equal
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic [3:0]         s_q, s_d;
  logic               m_q, m_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [WIDTH-1:0]   f_q, f_d;
  logic               cn_out_q, cn_out_d;
  logic               equal_q, equal_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SLICE_W-1:0] a_sl [NSLICE];
  logic [SLICE_W-1:0] b_sl [NSLICE];
  logic [SLICE_W-1:0] slice_f;
  logic               slice_cn4;
  logic [WIDTH-1:0]   merged;

  // merged = shadow with the current slice's output dropped into place.
  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slices
    assign a_sl[gi] = op_a_q[gi*SLICE_W +: SLICE_W];
    assign b_sl[gi] = op_b_q[gi*SLICE_W +: SLICE_W];
    assign merged[gi*SLICE_W +: SLICE_W] =
      (cnt_q == CW'(gi)) ? slice_f : shadow_q[gi*SLICE_W +: SLICE_W];
  end

  alu181_slice u_slice (
    .a   (a_sl[cnt_q]),
    .b   (b_sl[cnt_q]),
    .cn  (carry_q),
    .s   (s_q),
    .m   (m_q),
    .f   (slice_f),
    .cn4 (slice_cn4)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    s_d      = s_q;
    m_d      = m_q;
    carry_d  = carry_q;
    shadow_d = shadow_q;
    f_d      = f_q;
    cn_out_d = cn_out_q;
    equal_d  = equal_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_a_d  = chain ? f_q : a;
          op_b_d  = b;
          s_d     = s;
          m_d     = m;
          carry_d = cn;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        shadow_d = merged;
        carry_d  = slice_cn4;
        if (cnt_q == LAST) begin
          // Publish on the last slice so f and done are both visible during DONE.
          f_d      = merged;
          cn_out_d = slice_cn4;
          equal_d  = &merged;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      carry_q  <= 1'b1;
      shadow_q <= '0;
      f_q      <= '0;
      cn_out_q <= 1'b1;
      equal_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      s_q      <= s_d;
      m_q      <= m_d;
      carry_q  <= carry_d;
      shadow_q <= shadow_d;
      f_q      <= f_d;
      cn_out_q <= cn_out_d;
      equal_q  <= equal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign f      = f_q;
  assign cn_out = cn_out_q;
  assign equal  = equal_q;

endmodule

// File: tb/tb_alu181_seq.sv
// Directed bench for alu181_seq (WIDTH=16): handshake timing, arithmetic/logic results, chaining, reset.
module tb_alu181_seq;
  import alu181_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, m, cn, chain;
  logic [15:0] a, b;
  logic [3:0]  s;
  logic        busy, done, cn_out, equal;
  logic [15:0] f;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt, done_cycle, done_cnt;

  alu181_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .s(s), .m(m), .cn(cn),
    .chain(chain), .busy(busy), .done(done), .f(f), .cn_out(cn_out), .equal(equal)
  );

  always #5 clk = ~clk;

  // Raise start before edge 0, drop it at the negedge of cycle 'hold', observe 12 cycles.
  task automatic launch(input logic [15:0] ai, input logic [15:0] bi, input logic [3:0] si,
                        input logic mi, input logic cni, input logic chi,
                        input int hold, input bit scramble);
    @(negedge clk);
    a = ai; b = bi; s = si; m = mi; cn = cni; chain = chi; start = 1'b1;
    busy_cnt = 0; done_cycle = 0; done_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cycle == 0) done_cycle = c;
      end
      if (c == hold) start = 1'b0;
      if (scramble && c == 1) begin
        a = 16'($urandom); b = 16'($urandom); s = 4'($urandom);
        m = 1'($urandom); cn = 1'($urandom); chain = 1'($urandom);
      end
    end
    $display("op a=%h b=%h s=%b m=%b cn=%b chain=%b -> f=%h cn_out=%b equal=%b busy_cycles=%0d done_cycle=%0d",
             ai, bi, si, mi, cni, chi, f, cn_out, equal, busy_cnt, done_cycle);
  endtask

  task automatic test_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (f !== 16'h0000) begin n_fail++; $display("FAIL reset_f: got %h expected 0000", f); end
    n_checks++; if (cn_out !== 1'b1) begin n_fail++; $display("FAIL reset_cn_out: got %b expected 1", cn_out); end
    n_checks++; if (equal !== 1'b0) begin n_fail++; $display("FAIL reset_equal: got %b expected 0", equal); end
  endtask

  task automatic test_add_basic();
    launch(16'h3C5A, 16'h1506, S_ADD, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    n_checks++; if (busy_cnt !== 4) begin n_fail++; $display("FAIL add_busy_cycles: got %0d expected 4", busy_cnt); end
    n_checks++; if (done_cycle !== 5) begin n_fail++; $display("FAIL add_done_cycle: got %0d expected 5", done_cycle); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL add_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (f !== 16'h5160) begin n_fail++; $display("FAIL add_f: got %h expected 5160", f); end
    n_checks++; if (cn_out !== 1'b1) begin n_fail++; $display("FAIL add_cn_out: got %b expected 1", cn_out); end
    n_checks++; if (equal !== 1'b0) begin n_fail++; $display("FAIL add_equal: got %b expected 0", equal); end
  endtask

  task automatic test_carry_ripple();
    launch(16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    n_checks++; if (f !== 16'h0000) begin n_fail++; $display("FAIL ripple_f: got %h expected 0000", f); end
    n_checks++; if (cn_out !== 1'b0) begin n_fail++; $display("FAIL ripple_cn_out: got %b expected 0", cn_out); end
    n_checks++; if (equal !== 1'b0) begin n_fail++; $display("FAIL ripple_equal: got %b expected 0", equal); end
  endtask

  // Inputs are scrambled during RUN; the latched operands must still win.
  task automatic test_sub_equal_latched();
    launch(16'h1234, 16'h1234, S_SUB, 1'b0, 1'b1, 1'b0, 1, 1'b1);
    n_checks++; if (f !== 16'hFFFF) begin n_fail++; $display("FAIL sub_f: got %h expected ffff", f); end
    n_checks++; if (equal !== 1'b1) begin n_fail++; $display("FAIL sub_equal: got %b expected 1", equal); end
    n_checks++; if (cn_out !== 1'b1) begin n_fail++; $display("FAIL sub_cn_out: got %b expected 1", cn_out); end
  endtask

  task automatic test_xor_chain();
    launch(16'hA5A5, 16'hFFFF, S_XOR, 1'b1, 1'b1, 1'b0, 1, 1'b0);
    n_checks++; if (f !== 16'h5A5A) begin n_fail++; $display("FAIL xor_f: got %h expected 5a5a", f); end
    n_checks++; if (cn_out !== 1'b1) begin n_fail++; $display("FAIL xor_cn_out: got %b expected 1", cn_out); end
    launch(16'h1111, 16'h0001, S_ADD, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    n_checks++; if (f !== 16'h5A5B) begin n_fail++; $display("FAIL chain_f: got %h expected 5a5b", f); end
  endtask

  task automatic test_misc_functions();
    // s=0000 arithmetic with an active carry-in: A plus 1.
    launch(16'h00FF, 16'h5555, S_PASS_A, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    n_checks++; if (f !== 16'h0100) begin n_fail++; $display("FAIL inc_f: got %h expected 0100", f); end
    n_checks++; if (cn_out !== 1'b1) begin n_fail++; $display("FAIL inc_cn_out: got %b expected 1", cn_out); end
    // s=1111 arithmetic, no carry: A minus 1 with A=0 wraps to all ones.
    launch(16'h0000, 16'h1234, 4'b1111, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    n_checks++; if (f !== 16'hFFFF) begin n_fail++; $display("FAIL dec_f: got %h expected ffff", f); end
    n_checks++; if (equal !== 1'b1) begin n_fail++; $display("FAIL dec_equal: got %b expected 1", equal); end
    // s=1011 logic: A AND B.
    launch(16'hF0CC, 16'h3CAA, 4'b1011, 1'b1, 1'b1, 1'b0, 1, 1'b0);
    n_checks++; if (f !== 16'h3088) begin n_fail++; $display("FAIL and_f: got %h expected 3088", f); end
  endtask

  task automatic test_reset_mid_run();
    int late_done;
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; s = S_ADD; m = 1'b0; cn = 1'b1; chain = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    $display("mid-run reset: busy=%b done=%b f=%h cn_out=%b equal=%b", busy, done, f, cn_out, equal);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++; if (f !== 16'h0000) begin n_fail++; $display("FAIL midrst_f: got %h expected 0000", f); end
    n_checks++; if (equal !== 1'b0) begin n_fail++; $display("FAIL midrst_equal: got %b expected 0", equal); end
    @(negedge clk);
    rst = 1'b0;
    late_done = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) late_done++;
    end
    n_checks++; if (late_done !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses expected 0", late_done); end
    // First op after reset chains from f=0.
    launch(16'hAAAA, 16'h1234, S_ADD, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    n_checks++; if (done_cycle !== 5) begin n_fail++; $display("FAIL post_rst_done_cycle: got %0d expected 5", done_cycle); end
    n_checks++; if (f !== 16'h1234) begin n_fail++; $display("FAIL post_rst_chain_f: got %h expected 1234", f); end
  endtask

  // start stays high through RUN and DONE; only the first edge may accept it.
  task automatic test_start_held();
    launch(16'h0F0F, 16'h0101, S_ADD, 1'b0, 1'b1, 1'b0, 6, 1'b0);
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL held_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (busy_cnt !== 4) begin n_fail++; $display("FAIL held_busy_cycles: got %0d expected 4", busy_cnt); end
    n_checks++; if (f !== 16'h1010) begin n_fail++; $display("FAIL held_f: got %h expected 1010", f); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; cn = 1'b1; chain = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_add_basic();
    test_carry_ripple();
    test_sub_equal_latched();
    test_xor_chain();
    test_misc_functions();
    test_reset_mid_run();
    test_start_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
